idecode: RTL and testbench
==========================

Name: idecode

Overview:
- Instruction-decode stage of the 5-stage MIPS pipeline; consumes the fetch stage's IF/ID outputs (ID_ir, ID_npc).
- Holds the 32x32 register file and decodes control for R-type, lw, sw and beq.
- Registers everything into the ID/EX pipeline register that drives the EX stage.
- Accepts the WB write-back port and the MEM-stage branch-taken flush.

Parameters:
- None. Widths are fixed: 32-bit datapath, 5-bit register index.

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
ID_ir  in  32  instruction from IF/ID register
ID_npc  in  32  PC+4 from IF/ID register
MEM_PCSrc  in  1  branch taken in MEM; flush the instruction being decoded
WB_regwrite  in  1  write-back enable
WB_wreg  in  5  write-back destination register
WB_wdata  in  32  write-back data
EX_npc  out  32  registered ID_npc
EX_rd1  out  32  registered rs read data
EX_rd2  out  32  registered rt read data
EX_imm  out  32  registered sign-extended ID_ir[15:0]
EX_rt  out  5  registered ID_ir[20:16]
EX_rd  out  5  registered ID_ir[15:11]
EX_wb  out  2  {regwrite, memtoreg}
EX_m  out  3  {branch, memread, memwrite}
EX_ex  out  4  {regdst, aluop[1:0], alusrc}

Behaviour:
- Reset, on a clock edge with rst=1:
  - All EX_* outputs go to 0.
  - All 32 registers clear to 0.
  - A WB write presented in the same cycle is discarded.
- Latency: exactly 1 cycle. Values on ID_* in cycle n appear on EX_* after edge n+1. There is no stall input; the register loads every non-reset cycle.
- Opcode decode uses ID_ir[31:26]:
  - 0x00, R-type: regdst=1, alusrc=0, aluop=10, memtoreg=0, regwrite=1, memread=0, memwrite=0, branch=0.
  - 0x23, lw: regdst=0, alusrc=1, aluop=00, memtoreg=1, regwrite=1, memread=1, memwrite=0, branch=0.
  - 0x2B, sw: alusrc=1, aluop=00, memwrite=1. All other control bits 0.
  - 0x04, beq: aluop=01, branch=1. All other control bits 0.
  - Any other opcode: all control bits 0, so it executes as a NOP.
- Register file writes:
  - The write occurs on the rising edge when WB_regwrite=1 and WB_wreg != 0.
  - Register 0 is never written and always reads 0.
- Register file reads:
  - rs = ID_ir[25:21], rt = ID_ir[20:16].
  - Read is combinational from the array, sampled into EX_rd1/EX_rd2 at the edge.
- Same-cycle write/read bypass:
  - Condition: WB_regwrite=1, WB_wreg != 0 and WB_wreg equals rs (or rt).
  - EX_rd1 (or EX_rd2) takes WB_wdata, not the stale array value.
  - Both operands are bypassed if rs = rt = WB_wreg.
  - No bypass when WB_wreg=0.
- Sign extension: EX_imm = {16 copies of ID_ir[15], ID_ir[15:0]}.
- Flush, when MEM_PCSrc=1 at the edge:
  - EX_wb, EX_m and EX_ex load 0, inserting a bubble.
  - Datapath fields (EX_npc, EX_rd1, EX_rd2, EX_imm, EX_rt, EX_rd) load normally; their values are don't-care.
  - The WB write in the same cycle still commits.
- Simultaneous rst and MEM_PCSrc: rst wins.
- Reset mid-stream: one reset edge is sufficient. The next non-reset edge decodes normally from cleared registers.
- No combinational path from any input to any output.

Test Plan:
- Reset: rst=1 for 2 cycles with ID_ir=0x8C220004 and WB write r5=7 → all EX_*=0. A subsequent read of r5 gives EX_rd1=0.
- Write then read: WB write r3=0x12345678. Next cycle ID_ir=0x00631020 (add r2,r3,r3) → EX_rd1=EX_rd2=0x12345678, EX_rd=2, EX_ex=4'b1100, EX_wb=2'b10, EX_m=3'b000.
- Bypass: same cycle as WB write r4=0xDEADBEEF, ID_ir=0xAC840010 (sw r4,16(r4)) → EX_rd1=EX_rd2=0xDEADBEEF, EX_imm=0x00000010, EX_m=3'b001, EX_ex=4'b0001.
- Zero register: WB write r0=0xFFFFFFFF, then ID_ir=0x00000000 → EX_rd1=EX_rd2=0. Also in the same cycle with WB_wreg=0 → no bypass, reads 0.
- Branch, sign-extension and flush: ID_ir=0x1022FFFF (beq) → EX_imm=0xFFFFFFFF, EX_m=3'b100, EX_ex=4'b0010. Same instruction with MEM_PCSrc=1 → EX_wb, EX_m and EX_ex all 0.
- Unknown opcode: ID_ir=0x3C01ABCD (lui) → all control outputs 0. EX_npc equals the ID_npc from the previous cycle.

Source files
------------

// File: rtl/idecode.sv
// MIPS instruction-decode stage: 32x32 register file with write-back bypass,
// main control decode, and the ID/EX pipeline register.
module idecode (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ID_ir,
    input  logic [31:0] ID_npc,
    input  logic        MEM_PCSrc,
    input  logic        WB_regwrite,
    input  logic [4:0]  WB_wreg,
    input  logic [31:0] WB_wdata,
    output logic [31:0] EX_npc,
    output logic [31:0] EX_rd1,
    output logic [31:0] EX_rd2,
    output logic [31:0] EX_imm,
    output logic [4:0]  EX_rt,
    output logic [4:0]  EX_rd,
    output logic [1:0]  EX_wb,
    output logic [2:0]  EX_m,
    output logic [3:0]  EX_ex
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned RIDX = 5;
    localparam int unsigned NREG = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    logic [XLEN-1:0] regs [NREG];

    logic [RIDX-1:0] rs_c;
    logic [RIDX-1:0] rt_c;
    logic [5:0]      opcode_c;
    logic            wb_hit_c;
    logic [XLEN-1:0] rd1_c;
    logic [XLEN-1:0] rd2_c;
    logic [XLEN-1:0] imm_c;
    logic [1:0]      wb_c;
    logic [2:0]      m_c;
    logic [3:0]      ex_c;

    assign opcode_c = ID_ir[31:26];
    assign rs_c     = ID_ir[25:21];
    assign rt_c     = ID_ir[20:16];
    assign wb_hit_c = WB_regwrite && (WB_wreg != '0);
    assign imm_c    = {{16{ID_ir[15]}}, ID_ir[15:0]};

    // Operand read with same-cycle write-back bypass; r0 is hard zero.
    always_comb begin
        rd1_c = regs[rs_c];
        rd2_c = regs[rt_c];
        if (wb_hit_c && (WB_wreg == rs_c)) rd1_c = WB_wdata;
        if (wb_hit_c && (WB_wreg == rt_c)) rd2_c = WB_wdata;
        if (rs_c == '0) rd1_c = '0;
        if (rt_c == '0) rd2_c = '0;
    end

    // Main control: wb={regwrite,memtoreg} m={branch,memread,memwrite} ex={regdst,aluop,alusrc}.
    always_comb begin
        wb_c = 2'b00;
        m_c  = 3'b000;
        ex_c = 4'b0000;
        case (opcode_c)
            OP_RTYPE: begin
                wb_c = 2'b10;
                ex_c = 4'b1100;
            end
            OP_LW: begin
                wb_c = 2'b11;
                m_c  = 3'b010;
                ex_c = 4'b0001;
            end
            OP_SW: begin
                m_c  = 3'b001;
                ex_c = 4'b0001;
            end
            OP_BEQ: begin
                m_c  = 3'b100;
                ex_c = 4'b0010;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_hit_c) begin
            regs[WB_wreg] <= WB_wdata;
        end
    end

    // ID/EX pipeline register; a taken branch in MEM squashes only the control fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            EX_npc <= '0;
            EX_rd1 <= '0;
            EX_rd2 <= '0;
            EX_imm <= '0;
            EX_rt  <= '0;
            EX_rd  <= '0;
            EX_wb  <= '0;
            EX_m   <= '0;
            EX_ex  <= '0;
        end else begin
            EX_npc <= ID_npc;
            EX_rd1 <= rd1_c;
            EX_rd2 <= rd2_c;
            EX_imm <= imm_c;
            EX_rt  <= ID_ir[20:16];
            EX_rd  <= ID_ir[15:11];
            if (MEM_PCSrc) begin
                EX_wb <= '0;
                EX_m  <= '0;
                EX_ex <= '0;
            end else begin
                EX_wb <= wb_c;
                EX_m  <= m_c;
                EX_ex <= ex_c;
            end
        end
    end

endmodule

// File: tb/tb_idecode.sv
// Directed and randomized checks of idecode against a register-array reference model.
module tb_idecode;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ID_ir;
    logic [31:0] ID_npc;
    logic        MEM_PCSrc;
    logic        WB_regwrite;
    logic [4:0]  WB_wreg;
    logic [31:0] WB_wdata;
    logic [31:0] EX_npc, EX_rd1, EX_rd2, EX_imm;
    logic [4:0]  EX_rt, EX_rd;
    logic [1:0]  EX_wb;
    logic [2:0]  EX_m;
    logic [3:0]  EX_ex;

    int total = 0;
    int bad   = 0;

    logic [31:0] mregs [32];
    logic [31:0] e_npc, e_rd1, e_rd2, e_imm;
    logic [4:0]  e_rt, e_rd;
    logic [1:0]  e_wb;
    logic [2:0]  e_m;
    logic [3:0]  e_ex;
    logic        chk_dp;

    idecode dut (
        .clk(clk), .rst(rst), .ID_ir(ID_ir), .ID_npc(ID_npc), .MEM_PCSrc(MEM_PCSrc),
        .WB_regwrite(WB_regwrite), .WB_wreg(WB_wreg), .WB_wdata(WB_wdata),
        .EX_npc(EX_npc), .EX_rd1(EX_rd1), .EX_rd2(EX_rd2), .EX_imm(EX_imm),
        .EX_rt(EX_rt), .EX_rd(EX_rd), .EX_wb(EX_wb), .EX_m(EX_m), .EX_ex(EX_ex)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Control bundle {wb[1:0], m[2:0], ex[3:0]} from the opcode table.
    function automatic logic [8:0] ctrl_of(input logic [5:0] op);
        case (op)
            6'h00:   return {2'b10, 3'b000, 4'b1100};
            6'h23:   return {2'b11, 3'b010, 4'b0001};
            6'h2B:   return {2'b00, 3'b001, 4'b0001};
            6'h04:   return {2'b00, 3'b100, 4'b0010};
            default: return 9'd0;
        endcase
    endfunction

    task automatic step(input logic r, input logic [31:0] ir, input logic [31:0] npc,
                        input logic pcsrc, input logic we, input logic [4:0] wreg,
                        input logic [31:0] wdata);
        logic [4:0]  rs, rt;
        logic [8:0]  c;
        @(negedge clk);
        rst = r; ID_ir = ir; ID_npc = npc; MEM_PCSrc = pcsrc;
        WB_regwrite = we; WB_wreg = wreg; WB_wdata = wdata;
        rs = ir[25:21];
        rt = ir[20:16];
        chk_dp = 1'b1;
        if (r) begin
            {e_npc, e_rd1, e_rd2, e_imm} = '0;
            {e_rt, e_rd, e_wb, e_m, e_ex} = '0;
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        end else begin
            e_npc = npc;
            e_rd1 = (we && wreg != 0 && wreg == rs) ? wdata : mregs[rs];
            e_rd2 = (we && wreg != 0 && wreg == rt) ? wdata : mregs[rt];
            e_imm = 32'($signed(ir[15:0]));
            e_rt  = rt;
            e_rd  = ir[15:11];
            c = pcsrc ? 9'd0 : ctrl_of(ir[31:26]);
            {e_wb, e_m, e_ex} = c;
            chk_dp = !pcsrc;
            if (we && wreg != 0) mregs[wreg] = wdata;
        end
        @(posedge clk);
        #1;
        check("wb", 32'(EX_wb), 32'(e_wb));
        check("m",  32'(EX_m),  32'(e_m));
        check("ex", 32'(EX_ex), 32'(e_ex));
        if (chk_dp) begin
            check("npc", EX_npc, e_npc);
            check("rd1", EX_rd1, e_rd1);
            check("rd2", EX_rd2, e_rd2);
            check("imm", EX_imm, e_imm);
            check("rt",  32'(EX_rt), 32'(e_rt));
            check("rd",  32'(EX_rd), 32'(e_rd));
        end
    endtask

    initial begin
        logic [31:0] ir;
        logic [4:0]  wreg;
        logic [5:0]  op;
        rst = 1'b1; ID_ir = '0; ID_npc = '0; MEM_PCSrc = 1'b0;
        WB_regwrite = 1'b0; WB_wreg = '0; WB_wdata = '0;

        // reset with a pending lw and a write-back that must be dropped
        step(1, 32'h8C220004, 32'h100, 0, 1, 5'd5, 32'd7);
        step(1, 32'h8C220004, 32'h104, 0, 1, 5'd5, 32'd7);
        check("reset_npc", EX_npc, 32'd0);
        check("reset_m", 32'(EX_m), 32'd0);
        step(0, 32'h00A00000, 32'h108, 0, 0, 5'd0, 32'd0);
        check("reset_r5", EX_rd1, 32'd0);

        // write r3, then add r2,r3,r3
        step(0, 32'h00000000, 32'h10C, 0, 1, 5'd3, 32'h12345678);
        step(0, 32'h00631020, 32'h110, 0, 0, 5'd0, 32'd0);
        check("add_rd1", EX_rd1, 32'h12345678);
        check("add_rd", 32'(EX_rd), 32'd2);
        check("add_ex", 32'(EX_ex), 32'hC);

        // sw r4,16(r4) with r4 bypassed from write-back
        step(0, 32'hAC840010, 32'h114, 0, 1, 5'd4, 32'hDEADBEEF);
        check("byp_rd2", EX_rd2, 32'hDEADBEEF);
        check("byp_m", 32'(EX_m), 32'd1);

        // r0 is never written and never bypassed
        step(0, 32'h00000000, 32'h118, 0, 1, 5'd0, 32'hFFFFFFFF);
        step(0, 32'h00000000, 32'h11C, 0, 1, 5'd0, 32'hFFFFFFFF);
        check("r0_rd1", EX_rd1, 32'd0);

        // beq with negative offset, then flushed, then lui
        step(0, 32'h1022FFFF, 32'h120, 0, 0, 5'd0, 32'd0);
        check("beq_imm", EX_imm, 32'hFFFFFFFF);
        step(0, 32'h1022FFFF, 32'h124, 1, 1, 5'd9, 32'h00000099);
        step(0, 32'h01200000, 32'h128, 0, 0, 5'd0, 32'd0);
        check("flush_wb_commits", EX_rd1, 32'h00000099);
        step(0, 32'h3C01ABCD, 32'h12C, 0, 0, 5'd0, 32'd0);
        check("lui_npc", EX_npc, 32'h12C);

        // reset together with flush, then decode from cleared registers
        step(1, 32'h00631020, 32'h130, 1, 0, 5'd0, 32'd0);
        step(0, 32'h00631020, 32'h134, 0, 0, 5'd0, 32'd0);
        check("post_reset_r3", EX_rd1, 32'd0);

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 4))
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2B;
                3: op = 6'h04;
                default: op = 6'($urandom);
            endcase
            ir = $urandom;
            ir[31:26] = op;
            wreg = 5'($urandom);
            if ($urandom_range(0, 3) == 0) ir[25:21] = wreg;
            if ($urandom_range(0, 3) == 0) ir[20:16] = wreg;
            step($urandom_range(0, 39) == 0, ir, $urandom, $urandom_range(0, 7) == 0,
                 1'($urandom), wreg, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
